// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the pipelined controller.
//   alu_op_t    - ALUControl encodings driven to the datapath
//   Op*/Fn*     - instruction op-field (InstrD[24:23]) and funct (InstrD[21:19]) codes
//   Flag*       - bit positions of {N,Z,C,V} in the flag vectors
//   ctrl_t      - control bundle carried from D into the E stage
package ctrl_pkg;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluEqv = 3'b001,
    AluMul = 3'b010,
    AluDiv = 3'b011,
    AluMod = 3'b100,
    AluMov = 3'b101
  } alu_op_t;

  localparam logic [1:0] OpAlu    = 2'b00;
  localparam logic [1:0] OpBranch = 2'b01;
  localparam logic [1:0] OpMem    = 2'b10;
  localparam logic [1:0] OpNop    = 2'b11;

  localparam logic [2:0] FnAdd = 3'b000;
  localparam logic [2:0] FnMul = 3'b001;
  localparam logic [2:0] FnDiv = 3'b010;
  localparam logic [2:0] FnMod = 3'b011;
  localparam logic [2:0] FnMov = 3'b100;
  localparam logic [2:0] FnEqv = 3'b101;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef struct packed {
    logic       cond;
    logic [1:0] flag_write;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       pc_src;
    logic       mem_to_reg;
    logic       alu_src;
    alu_op_t    alu_control;
    logic       no_write;
    logic       is_div;
  } ctrl_t;

endpackage

// File: rtl/cond_unit.sv
// cond_unit: condition evaluation and next-flag computation for the E stage.
//   cond       - registered condition bit (0: always, 1: execute when Z set)
//   flags      - current architectural flags {N,Z,C,V}
//   alu_flags  - flags produced by the ALU this cycle
//   flag_write - [1] updates N,Z; [0] updates C,V (already qualified by caller)
//   cond_ex    - instruction in E executes
//   flags_next - flag register next state
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       cond,
  input  logic [3:0] flags,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_write,
  output logic       cond_ex,
  output logic [3:0] flags_next
);

  always_comb begin
    cond_ex    = cond ? flags[FlagZ] : 1'b1;
    flags_next = flags;
    if (cond_ex && flag_write[1]) begin
      flags_next[FlagN] = alu_flags[FlagN];
      flags_next[FlagZ] = alu_flags[FlagZ];
    end
    if (cond_ex && flag_write[0]) begin
      flags_next[FlagC] = alu_flags[FlagC];
      flags_next[FlagV] = alu_flags[FlagV];
    end
  end

endmodule

// File: rtl/pipe_ctrl_mc.sv
// pipe_ctrl_mc: D/E/M/W pipelined controller with optional multi-cycle DIV/MOD.
// Build option: define MULTICYCLE_DIV_EN to hold DIV/MOD in E for DIV_LAT cycles;
// otherwise DIV/MOD are single-cycle and ExBusyE/DivStartE are tied low.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   InstrD            - instruction bits [25:10] in decode
//   ALUFlagsE         - ALU flags {N,Z,C,V} from E
//   FlushE            - bubble E (ignored while E is busy)
//   RegSrcD, ImmSrcD  - decode-stage datapath selects
//   ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE - E-stage controls
//   ExBusyE, DivStartE - multi-cycle divide status / start pulse
//   MemWriteM, RegWriteM - M-stage controls
//   MemtoRegW, RegWriteW, PCSrcW - W-stage controls
//   PCWrPendingF      - a PC write is in flight in D, E or M
module pipe_ctrl_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = 8,
  parameter logic [3:0]  PC_REG  = 4'd9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [25:10]  InstrD,
  input  logic [3:0]    ALUFlagsE,
  input  logic          FlushE,
  output logic [1:0]    RegSrcD,
  output logic [1:0]    ImmSrcD,
  output logic          ALUSrcE,
  output logic [2:0]    ALUControlE,
  output logic          BranchTakenE,
  output logic          MemtoRegE,
  output logic          ExBusyE,
  output logic          DivStartE,
  output logic          MemWriteM,
  output logic          RegWriteM,
  output logic          MemtoRegW,
  output logic          RegWriteW,
  output logic          PCSrcW,
  output logic          PCWrPendingF
);

  // ---------------- Decode ----------------
  logic [9:0] main_dec;
  logic [1:0] reg_src_d, imm_src_d;
  logic       alu_src_d, mem_to_reg_d, reg_write_main, mem_write_d, branch_d, alu_op_d;
  logic       reg_write_d, pc_src_d, no_write_d, is_div_d, alu_nop;
  logic [1:0] flag_write_d;
  alu_op_t    alu_control_d;
  ctrl_t      ctrl_d;
  logic [2:0] funct;
  logic       s_bit;

  assign funct = InstrD[21:19];
  assign s_bit = InstrD[18];

  always_comb begin
    main_dec = '0;
    unique case (InstrD[24:23])
      OpAlu:    main_dec = InstrD[22] ? 10'b0000101001 : 10'b0000001001;
      OpMem:    main_dec = InstrD[18] ? 10'b0001111000 : 10'b1001110100;
      OpBranch: main_dec = 10'b0110100010;
      default:  main_dec = '0;
    endcase
  end

  assign {reg_src_d, imm_src_d, alu_src_d, mem_to_reg_d, reg_write_main, mem_write_d,
          branch_d, alu_op_d} = main_dec;

  always_comb begin
    alu_control_d = AluAdd;
    flag_write_d  = '0;
    no_write_d    = 1'b0;
    is_div_d      = 1'b0;
    alu_nop       = 1'b0;
    if (alu_op_d) begin
      unique case (funct)
        FnAdd: alu_control_d = AluAdd;
        FnMul: alu_control_d = AluMul;
        FnDiv: begin
          alu_control_d = AluDiv;
          is_div_d      = 1'b1;
        end
        FnMod: begin
          alu_control_d = AluMod;
          is_div_d      = 1'b1;
        end
        FnMov: alu_control_d = AluMov;
        FnEqv: begin
          alu_control_d = AluEqv;
          no_write_d    = 1'b1;
        end
        default: alu_nop = 1'b1;
      endcase
      if (!alu_nop) begin
        flag_write_d[1] = s_bit;
        flag_write_d[0] = s_bit && (funct != FnMov);
      end
    end
  end

  // EQV still counts as a register writer here; NoWrite suppresses it in E.
  assign reg_write_d = reg_write_main && !alu_nop;
  assign pc_src_d    = ((InstrD[17:14] == PC_REG) && reg_write_d) || branch_d;

  always_comb begin
    ctrl_d             = '0;
    ctrl_d.cond        = InstrD[25];
    ctrl_d.flag_write  = flag_write_d;
    ctrl_d.branch      = branch_d;
    ctrl_d.mem_write   = mem_write_d;
    ctrl_d.reg_write   = reg_write_d;
    ctrl_d.pc_src      = pc_src_d;
    ctrl_d.mem_to_reg  = mem_to_reg_d;
    ctrl_d.alu_src     = alu_src_d;
    ctrl_d.alu_control = alu_control_d;
    ctrl_d.no_write    = no_write_d;
    ctrl_d.is_div      = is_div_d;
  end

  // ---------------- Execute ----------------
  ctrl_t      e_q, e_d;
  logic [3:0] flags_q, flags_next;
  logic       cond_ex, busy, div_start;

  cond_unit u_cond_unit (
    .cond       (e_q.cond),
    .flags      (flags_q),
    .alu_flags  (ALUFlagsE),
    .flag_write (e_q.flag_write & {2{~busy}}),
    .cond_ex    (cond_ex),
    .flags_next (flags_next)
  );

`ifdef MULTICYCLE_DIV_EN
  localparam int unsigned      CntW    = $clog2(DIV_LAT + 1);
  localparam logic [CntW-1:0]  CntLoad = CntW'(DIV_LAT - 1);

  logic [CntW-1:0] cnt_q, cnt_eff;
  logic            running_q;

  // The load value is used in the entry cycle itself, so E is occupied for
  // exactly DIV_LAT cycles and the last one (count 0) is the writing cycle.
  assign div_start = !running_q && e_q.is_div && cond_ex && (DIV_LAT > 1);
  assign cnt_eff   = div_start ? CntLoad : cnt_q;
  assign busy      = (cnt_eff != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else begin
      running_q <= busy;
      cnt_q     <= busy ? cnt_eff - CntW'(1) : '0;
    end
  end
`else
  logic unused_div;
  assign unused_div = e_q.is_div ^ (DIV_LAT == 0);
  assign div_start  = 1'b0;
  assign busy       = 1'b0;
`endif

  always_comb begin
    e_d = ctrl_d;
    if (busy) begin
      e_d = e_q;
    end else if (FlushE) begin
      e_d.flag_write = '0;
      e_d.branch     = 1'b0;
      e_d.mem_write  = 1'b0;
      e_d.reg_write  = 1'b0;
      e_d.pc_src     = 1'b0;
      e_d.mem_to_reg = 1'b0;
      e_d.is_div     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q     <= '0;
      flags_q <= '0;
    end else begin
      e_q     <= e_d;
      flags_q <= flags_next;
    end
  end

  logic exec_e, reg_write_e, mem_write_e, pc_src_e;
  assign exec_e      = cond_ex && !busy;
  assign reg_write_e = e_q.reg_write && exec_e && !e_q.no_write;
  assign mem_write_e = e_q.mem_write && exec_e;
  assign pc_src_e    = e_q.pc_src && exec_e;

  // ---------------- Memory / Writeback ----------------
  logic mem_write_m, reg_write_m, mem_to_reg_m, pc_src_m;
  logic reg_write_w, mem_to_reg_w, pc_src_w;

  always_ff @(posedge clk) begin
    if (reset || busy) begin
      mem_write_m  <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pc_src_m     <= 1'b0;
    end else begin
      mem_write_m  <= mem_write_e;
      reg_write_m  <= reg_write_e;
      mem_to_reg_m <= e_q.mem_to_reg;
      pc_src_m     <= pc_src_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pc_src_w     <= 1'b0;
    end else begin
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      pc_src_w     <= pc_src_m;
    end
  end

  // ---------------- Outputs ----------------
  logic unused_instr;
  assign unused_instr = ^InstrD[13:10];

  assign RegSrcD      = reg_src_d;
  assign ImmSrcD      = imm_src_d;
  assign ALUSrcE      = e_q.alu_src;
  assign ALUControlE  = e_q.alu_control;
  assign BranchTakenE = e_q.branch && exec_e;
  assign MemtoRegE    = e_q.mem_to_reg;
  assign ExBusyE      = busy;
  assign DivStartE    = div_start;
  assign MemWriteM    = mem_write_m;
  assign RegWriteM    = reg_write_m;
  assign MemtoRegW    = mem_to_reg_w;
  assign RegWriteW    = reg_write_w;
  assign PCSrcW       = pc_src_w;
  assign PCWrPendingF = pc_src_d || e_q.pc_src || pc_src_m;

endmodule

// File: tb/tb_pipe_ctrl_mc.sv
// tb_pipe_ctrl_mc: directed self-checking bench for pipe_ctrl_mc (DIV_LAT=8, PC_REG=9).
// Expectations follow MULTICYCLE_DIV_EN when the bench is built with it defined.
module tb_pipe_ctrl_mc;

  logic         clk = 1'b0;
  logic         reset;
  logic [25:10] InstrD;
  logic [3:0]   ALUFlagsE;
  logic         FlushE;
  logic [1:0]   RegSrcD, ImmSrcD;
  logic         ALUSrcE;
  logic [2:0]   ALUControlE;
  logic         BranchTakenE, MemtoRegE, ExBusyE, DivStartE, MemWriteM, RegWriteM;
  logic         MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_mc #(
    .DIV_LAT (8),
    .PC_REG  (4'd9)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .InstrD       (InstrD),
    .ALUFlagsE    (ALUFlagsE),
    .FlushE       (FlushE),
    .RegSrcD      (RegSrcD),
    .ImmSrcD      (ImmSrcD),
    .ALUSrcE      (ALUSrcE),
    .ALUControlE  (ALUControlE),
    .BranchTakenE (BranchTakenE),
    .MemtoRegE    (MemtoRegE),
    .ExBusyE      (ExBusyE),
    .DivStartE    (DivStartE),
    .MemWriteM    (MemWriteM),
    .RegWriteM    (RegWriteM),
    .MemtoRegW    (MemtoRegW),
    .RegWriteW    (RegWriteW),
    .PCSrcW       (PCSrcW),
    .PCWrPendingF (PCWrPendingF)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // cond, op, imm bit22, funct, S bit18, Rd
  function automatic logic [25:10] mk(input logic c, input logic [1:0] op, input logic i,
                                      input logic [2:0] fn, input logic s,
                                      input logic [3:0] rd);
    logic [25:10] v;
    v         = '0;
    v[25]     = c;
    v[24:23]  = op;
    v[22]     = i;
    v[21:19]  = fn;
    v[18]     = s;
    v[17:14]  = rd;
    return v;
  endfunction

  logic [25:10] i_nop, i_adds1, i_beq, i_eqvs2, i_mov9, i_put3, i_get4, i_adds5;
  logic [25:10] i_get9, i_put9, i_nopf9, i_eqv9, i_mul8, i_nopf8, i_divc, i_div;
  logic         seen;

  initial begin
    i_nop   = mk(1'b0, 2'b11, 1'b0, 3'd0, 1'b0, 4'd0);
    i_adds1 = mk(1'b0, 2'b00, 1'b1, 3'd0, 1'b1, 4'd1);
    i_beq   = mk(1'b1, 2'b01, 1'b0, 3'd0, 1'b0, 4'd0);
    i_eqvs2 = mk(1'b0, 2'b00, 1'b0, 3'd5, 1'b1, 4'd2);
    i_mov9  = mk(1'b0, 2'b00, 1'b0, 3'd4, 1'b0, 4'd9);
    i_put3  = mk(1'b0, 2'b10, 1'b1, 3'd0, 1'b0, 4'd3);
    i_get4  = mk(1'b0, 2'b10, 1'b1, 3'd0, 1'b1, 4'd4);
    i_adds5 = mk(1'b0, 2'b00, 1'b1, 3'd0, 1'b1, 4'd5);
    i_get9  = mk(1'b0, 2'b10, 1'b1, 3'd0, 1'b1, 4'd9);
    i_put9  = mk(1'b0, 2'b10, 1'b1, 3'd0, 1'b0, 4'd9);
    i_nopf9 = mk(1'b0, 2'b00, 1'b0, 3'd6, 1'b0, 4'd9);
    i_eqv9  = mk(1'b0, 2'b00, 1'b0, 3'd5, 1'b1, 4'd9);
    i_mul8  = mk(1'b0, 2'b00, 1'b0, 3'd1, 1'b0, 4'd8);
    i_nopf8 = mk(1'b0, 2'b00, 1'b0, 3'd6, 1'b0, 4'd8);
    i_divc  = mk(1'b1, 2'b00, 1'b0, 3'd2, 1'b0, 4'd6);
    i_div   = mk(1'b0, 2'b00, 1'b0, 3'd2, 1'b0, 4'd7);

    // Reset state and decode-stage outputs (pipeline held clear by reset).
    reset     = 1'b1;
    FlushE    = 1'b0;
    ALUFlagsE = 4'b0000;
    InstrD    = i_nop;
    tick();
    tick();
    chkv("reset_outputs", 32'({ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, ExBusyE,
                               DivStartE, MemWriteM, RegWriteM, MemtoRegW, RegWriteW,
                               PCSrcW, PCWrPendingF}), 32'd0);
    chkv("dec_nop", 32'({RegSrcD, ImmSrcD}), 32'h0);
    InstrD = i_get9;  #1;
    chkv("dec_get", 32'({RegSrcD, ImmSrcD}), 32'h1);
    chk1("pend_get_rd9", PCWrPendingF, 1'b1);
    InstrD = i_put9;  #1;
    chkv("dec_put", 32'({RegSrcD, ImmSrcD}), 32'h9);
    chk1("pend_put_rd9", PCWrPendingF, 1'b0);
    InstrD = i_beq;   #1;
    chkv("dec_branch", 32'({RegSrcD, ImmSrcD}), 32'h6);
    chk1("pend_branch", PCWrPendingF, 1'b1);
    InstrD = i_nopf9; #1;
    chk1("pend_nop_funct", PCWrPendingF, 1'b0);
    InstrD = i_eqv9;  #1;
    chk1("pend_eqv_rd9", PCWrPendingF, 1'b1);
    InstrD = i_nop;
    tick();
    reset = 1'b0;

    // ADD S=1 sets Z, then a conditional branch is taken.
    InstrD    = i_adds1;
    ALUFlagsE = 4'b0100;
    tick();
    chk1("add_alusrc_e", ALUSrcE, 1'b1);
    chkv("add_ctl_e", 32'(ALUControlE), 32'd0);
    InstrD = i_beq;
    tick();
    chk1("beq_taken", BranchTakenE, 1'b1);
    chk1("add_regwrite_m", RegWriteM, 1'b1);

    // EQV S=1 clears Z and writes no register.
    InstrD    = i_eqvs2;
    ALUFlagsE = 4'b0000;
    tick();
    chkv("eqv_ctl_e", 32'(ALUControlE), 32'd1);
    chk1("add_regwrite_w", RegWriteW, 1'b1);
    InstrD = i_beq;
    tick();
    chk1("eqv_regwrite_m", RegWriteM, 1'b0);
    chk1("beq_not_taken", BranchTakenE, 1'b0);
    chk1("beq_pcsrc_w", PCSrcW, 1'b1);
    InstrD = i_nop;
    tick();
    chk1("eqv_regwrite_w", RegWriteW, 1'b0);
    tick();

    // MOV to PC: pending through D, E, M; then PCSrcW.
    InstrD = i_mov9; #1;
    chk1("mov_pend_d", PCWrPendingF, 1'b1);
    tick();
    InstrD = i_nop; #1;
    chk1("mov_pend_e", PCWrPendingF, 1'b1);
    tick();
    chk1("mov_pend_m", PCWrPendingF, 1'b1);
    chk1("mov_pcsrc_w_early", PCSrcW, 1'b0);
    tick();
    chk1("mov_pcsrc_w", PCSrcW, 1'b1);
    chk1("mov_pend_done", PCWrPendingF, 1'b0);

    // PUT / GET memory controls.
    InstrD = i_put3;
    tick();
    chk1("put_memtoreg_e", MemtoRegE, 1'b1);
    InstrD = i_get4;
    tick();
    chk1("put_memwrite_m", MemWriteM, 1'b1);
    chk1("put_regwrite_m", RegWriteM, 1'b0);
    InstrD = i_nop;
    tick();
    chk1("get_memwrite_m", MemWriteM, 1'b0);
    tick();
    chk1("get_memtoreg_w", MemtoRegW, 1'b1);
    chk1("get_regwrite_w", RegWriteW, 1'b1);

    // FlushE bubbles an ADD S: no register write and no flag update.
    ALUFlagsE = 4'b0100;
    FlushE    = 1'b1;
    InstrD    = i_adds5;
    tick();
    FlushE = 1'b0;
    InstrD = i_beq;
    tick();
    chk1("flush_regwrite_m", RegWriteM, 1'b0);
    chk1("flush_no_flag_write", BranchTakenE, 1'b0);
    ALUFlagsE = 4'b0000;
    InstrD    = i_nop;
    tick();

    // MUL decode and reserved funct as NOP.
    InstrD = i_mul8;
    tick();
    chkv("mul_ctl_e", 32'(ALUControlE), 32'd2);
    InstrD = i_nopf8;
    tick();
    InstrD = i_nop;
    tick();
    chk1("nopf_regwrite_m", RegWriteM, 1'b0);
    chk1("mul_regwrite_w", RegWriteW, 1'b1);
    tick();

    // Conditional DIV with Z=0 is skipped in one cycle.
    InstrD = i_divc;
    tick();
    chkv("divskip_ctl_e", 32'(ALUControlE), 32'd3);
    chkv("divskip_busy_start", 32'({ExBusyE, DivStartE}), 32'd0);
    InstrD = i_nop;
    tick();
    chk1("divskip_regwrite_m", RegWriteM, 1'b0);
    chk1("divskip_busy_after", ExBusyE, 1'b0);
    tick();

    // Executing DIV.
    InstrD = i_div;
    tick();
`ifdef MULTICYCLE_DIV_EN
    chk1("div_start_t0", DivStartE, 1'b1);
    chk1("div_busy_t0", ExBusyE, 1'b1);
    InstrD = i_nop;
    FlushE = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chkv($sformatf("div_busy_t%0d", k), 32'({ExBusyE, DivStartE, RegWriteM}), 32'b100);
    end
    FlushE = 1'b0;
    tick();
    chkv("div_final_t7", 32'({ExBusyE, DivStartE, RegWriteM}), 32'b000);
    tick();
    chk1("div_regwrite_m", RegWriteM, 1'b1);
    chk1("div_regwrite_w_early", RegWriteW, 1'b0);
    tick();
    chk1("div_regwrite_w", RegWriteW, 1'b1);

    // Back-to-back DIV, then reset in the third busy cycle of the second.
    InstrD = i_div;
    tick();
    chk1("b2b_start0", DivStartE, 1'b1);
    for (int k = 1; k <= 7; k++) tick();
    chkv("b2b_final0", 32'({ExBusyE, DivStartE}), 32'd0);
    tick();
    chk1("b2b_start1", DivStartE, 1'b1);
    InstrD = i_nop;
    tick();
    tick();
    chk1("b2b_busy_c3", ExBusyE, 1'b1);
    reset = 1'b1;
    tick();
    chk1("rst_mid_busy", ExBusyE, 1'b0);
    reset = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      seen = seen | RegWriteW | RegWriteM | ExBusyE;
    end
    chk1("rst_div_no_write", seen, 1'b0);
`else
    chkv("div_single_busy_start", 32'({ExBusyE, DivStartE}), 32'd0);
    InstrD = i_nop;
    tick();
    chk1("div_regwrite_m", RegWriteM, 1'b1);
    tick();
    chk1("div_regwrite_w", RegWriteW, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
